// File: rtl/connect4_pkg.sv
// Shared Connect-4 board geometry, cell codes and the drop FSM state type.
// Cell (r,c) lives at bit (r*COLS+c)*CELL_W of the packed, row-major board.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int CELL_W  = 2;
  localparam int BOARD_W = ROWS * COLS * CELL_W;
  localparam int IDX_W   = 7;

  localparam logic [CELL_W-1:0] EMPTY   = 2'b00;
  localparam logic [CELL_W-1:0] PLAYER1 = 2'b01;
  localparam logic [CELL_W-1:0] PLAYER2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PLACE_ACK,
    ERR_ACK
  } drop_state_t;

  function automatic logic [IDX_W-1:0] cell_base(input logic [2:0] row,
                                                 input logic [2:0] col);
    logic [IDX_W-1:0] idx;
    idx = ({4'd0, row} * 7'(COLS) + {4'd0, col}) * 7'(CELL_W);
    return idx;
  endfunction

endpackage

// File: rtl/token_drop_controller.sv
// Owns the Connect-4 board and drops one token per accepted move, scanning the
// chosen column bottom-up one row per cycle, then pulsing done or error.
module token_drop_controller
  import connect4_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_board,
  input  logic               move_valid,
  input  logic [2:0]         move_column,
  input  logic [1:0]         move_player,
  output logic               move_ready,
  output logic [BOARD_W-1:0] board_state,
  output logic               drop_done,
  output logic               drop_error,
  output logic [2:0]         drop_row,
  output logic [2:0]         drop_col,
  output logic               busy,
  output logic               board_full
);

  drop_state_t        state_reg, state_next;
  logic [2:0]         col_reg;
  logic [1:0]         player_reg;
  logic [2:0]         scan_row_reg;
  logic [BOARD_W-1:0] board_reg;
  logic [2:0]         drop_row_reg;
  logic [2:0]         drop_col_reg;

  logic               accept;
  logic               move_ok;
  logic               place;
  logic               step_up;
  logic [CELL_W-1:0]  scan_cell;
  logic [COLS-1:0]    top_occupied;

  assign move_ready = (state_reg == IDLE) && !clear_board;
  assign move_ok    = (move_column < 3'(COLS)) &&
                      ((move_player == PLAYER1) || (move_player == PLAYER2));
  assign scan_cell  = board_reg[cell_base(scan_row_reg, col_reg) +: CELL_W];

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    place      = 1'b0;
    step_up    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (move_valid && move_ready) begin
          accept     = 1'b1;
          state_next = move_ok ? SCAN : ERR_ACK;
        end
      end
      SCAN: begin
        if (scan_cell == EMPTY) begin
          place      = 1'b1;
          state_next = PLACE_ACK;
        end else if (scan_row_reg == 3'd0) begin
          state_next = ERR_ACK;
        end else begin
          step_up = 1'b1;
        end
      end
      PLACE_ACK: state_next = IDLE;
      ERR_ACK:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      col_reg      <= '0;
      player_reg   <= '0;
      scan_row_reg <= '0;
      board_reg    <= '0;
      drop_row_reg <= '0;
      drop_col_reg <= '0;
    end else if (clear_board) begin
      // New game: wipe everything and abandon any move in flight.
      state_reg    <= IDLE;
      scan_row_reg <= '0;
      board_reg    <= '0;
      drop_row_reg <= '0;
      drop_col_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && move_ok) begin
        col_reg      <= move_column;
        player_reg   <= move_player;
        scan_row_reg <= 3'(ROWS - 1);
      end
      if (step_up) begin
        scan_row_reg <= scan_row_reg - 3'd1;
      end
      if (place) begin
        board_reg[cell_base(scan_row_reg, col_reg) +: CELL_W] <= player_reg;
        drop_row_reg <= scan_row_reg;
        drop_col_reg <= col_reg;
      end
    end
  end

  // The board is full exactly when every top-row cell is occupied.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_top
    assign top_occupied[gi] = board_reg[gi*CELL_W +: CELL_W] != EMPTY;
  end

  assign board_full  = &top_occupied;
  assign board_state = board_reg;
  assign drop_done   = (state_reg == PLACE_ACK);
  assign drop_error  = (state_reg == ERR_ACK);
  assign drop_row    = drop_row_reg;
  assign drop_col    = drop_col_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: doc/token_drop_controller.md
Name: token_drop_controller

Overview:
- Consumes column selections from the move sources (random_col_generator or the player input path) and drops a token into the lowest empty row of that column.
- Owns the authoritative 6x7 Connect-4 board register and publishes board_state back to the column generator, the win checker and the VGA renderer.
- Scans the chosen column bottom-up, one row per cycle. Reports a placement (row/col) or an error: column full, or bad column/player.

Parameters:
- ROWS, 6, board rows; row 0 = top, row ROWS-1 = bottom.
- COLS, 7, board columns.
- CELL_W, 2, bits per cell; cell (r,c) occupies board_state[(r*COLS+c)*CELL_W +: CELL_W].

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clear_board  input  1  synchronous board wipe / new game.
- move_valid  input  1  column request present.
- move_column  input  3  requested column, 0..COLS-1.
- move_player  input  2  token owner: 01 = player 1, 10 = player 2.
- move_ready  output  1  high when a request can be accepted.
- board_state  output  84  registered board, row-major, row 0 in the LSBs.
- drop_done  output  1  one-cycle pulse: token placed.
- drop_error  output  1  one-cycle pulse: request rejected, board unchanged.
- drop_row  output  3  row of the last placement.
- drop_col  output  3  column of the last placement.
- busy  output  1  FSM not in IDLE.
- board_full  output  1  all top-row cells non-empty (combinational from the board register).

Behaviour:
- Reset (async): board = 0, FSM = IDLE.
  - drop_done, drop_error, drop_row, drop_col, busy = 0; move_ready = 1.
  - Reset is honoured in any state, including mid-scan; a partially processed move is discarded.
- FSM states: IDLE, SCAN, PLACE_ACK, ERR_ACK.
- Handshake: move_ready = (state == IDLE) && !clear_board.
  - Accept on an edge where move_valid && move_ready.
  - Latch column and player; set scan_row = ROWS-1.
- Validation on accept:
  - If move_column >= COLS, or move_player is 00 or 11: go to ERR_ACK.
  - Otherwise go to SCAN.
- SCAN, one cycle per row:
  - If cell(scan_row, col) == 00: write player code into it, set drop_row = scan_row and drop_col = col, go to PLACE_ACK.
  - Else if scan_row == 0: go to ERR_ACK (column full).
  - Else decrement scan_row.
- PLACE_ACK: drop_done = 1 for exactly this cycle; board already shows the new token. Next state IDLE.
- ERR_ACK: drop_error = 1 for exactly this cycle; board untouched; drop_row and drop_col keep their old values. Next state IDLE.
- Latency, counted from the accept edge:
  - Column holding k tokens (k < ROWS): drop_done asserted in the cycle after edge k+1. Empty column: 2nd cycle after accept.
  - Full column: drop_error asserted after ROWS+1 cycles.
  - Invalid column/player: drop_error in the 1st cycle after accept.
- clear_board:
  - Highest priority below rst, in any state.
  - Next edge: board = 0, FSM = IDLE, pending move discarded, no done/error pulse.
  - drop_row and drop_col reset to 0.
- move_valid held high after completion is accepted again once in IDLE. Upstream must deassert valid on drop_done or drop_error.
- Only one cell is written per move; no other board bits change.
- Row and column are 3-bit unsigned. Cell index arithmetic uses a width of at least 7 bits (max index 82).

Decomposition:
- connect4_pkg holds:
  - ROWS, COLS, CELL_W and BOARD_W = ROWS*COLS*CELL_W.
  - Cell codes EMPTY = 2'b00, PLAYER1 = 2'b01, PLAYER2 = 2'b10.
  - Function cell_base(row, col) returning the board bit index.
  - drop_state_t enum.
- No sub-module is needed: a single FSM plus the board register. The package function replaces a separate indexer.

Test Plan:
- Empty board; move col 3, player 01 → drop_done 2 cycles after accept; drop_row = 5, drop_col = 3; board_state[77:76] = 01, all other bits 0.
- Then move col 3, player 10 → drop_done 3 cycles after accept; drop_row = 4; board_state[63:62] = 10; bits [77:76] still 01.
- Six alternating drops in col 0, then a 7th → drop_error 7 cycles after accept; board_state bit-identical before and after; board_full = 0.
- move_column = 7 or move_player = 11 → drop_error in the 1st cycle after accept; no board change; move_ready back high the following cycle.
- Assert rst mid-SCAN (col holding 4 tokens, 2 cycles in) → board = 0, all outputs 0, move_ready = 1; no drop_done afterwards.
- Fill the top row of all 7 columns → board_full = 1. Then pulse clear_board during a SCAN → board = 0, board_full = 0, no drop_done or drop_error pulse, FSM back in IDLE.
